demux1_4_rr_dispatcher: RTL and testbench
=========================================

DEMUX1_4_RR_DISPATCHER -- requirements
Module: demux1_4_rr_dispatcher

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, width of the dispatched data word.
REQ-002 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  DATA_W  upstream word.
REQ-007 ch_mask  input  4  per-channel enable; bit k=1 lets channel k receive words.
REQ-008 out_valid  output  4  one-hot valid; bit k = word presented to channel k.
REQ-009 out_ready  input  4  per-channel downstream ready.
REQ-010 out_data  output  DATA_W  held word, shared by all channels.
REQ-011 sel  output  2  target channel of the held word.
REQ-012 busy  output  1  holding register full.

Function
REQ-013 The block SHALL hold one word in a holding register with two states: EMPTY and FULL.
REQ-014 Accept: in_valid & in_ready SHALL load in_data into the register at the next edge.
REQ-015 Dispatch ("fire"): FULL & out_ready[sel] SHALL release the word at the edge.
REQ-016 in_ready = (ch_mask != 0) & (EMPTY | fire); accept and dispatch in the same cycle SHALL sustain one word per cycle.
REQ-017 Transitions: EMPTY->FULL on accept; FULL->EMPTY on fire without accept; FULL->FULL on fire with accept or on no fire.
REQ-018 A round-robin pointer ptr[1:0] SHALL select the target at load time: target = first channel k with ch_mask[k]=1, searching ptr, ptr+1, ... mod 4.
REQ-019 On every fire, ptr SHALL become sel+1 mod 4 (wrap 3->0).
REQ-020 For a load coinciding with a fire, the search SHALL start from the updated ptr (sel+1).
REQ-021 out_valid SHALL be one-hot at bit sel while FULL and all-zero while EMPTY; out_data and sel SHALL stay stable while FULL and not fired.
REQ-022 ch_mask changes SHALL NOT retarget a word already held; they apply to the next load only.
REQ-023 ch_mask = 0 SHALL force in_ready=0; a held word SHALL still dispatch to its target.
REQ-024 out_ready on non-target channels SHALL be ignored.
REQ-025 busy SHALL equal FULL.

Reset
REQ-026 rst_n low SHALL immediately force: state EMPTY, ptr=0, sel=0, out_valid=0, out_data=0, busy=0, counters 0; a held word SHALL be discarded.
REQ-027 in_ready SHALL be (ch_mask != 0) during and after reset; the first accept after deassertion SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-028 Macro DEMUX1_4_RR_DISPATCHER_CNT_EN defined: output ch_cnt [31:0] SHALL exist, byte k = 8-bit count of fires on channel k, wrapping 255->0, cleared by reset.
REQ-029 Macro undefined: ch_cnt and its counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Mask 4'hF, out_ready 4'hF, words 0x10..0x17 back-to-back -> one word per cycle, sel sequence 0,1,2,3,0,1,2,3, in_ready constantly 1.
REQ-031 Mask 4'b1010, all ready, 4 words -> targets 1,3,1,3; out_valid never 4'b0001 or 4'b0100.
REQ-032 Target 2 with out_ready[2]=0 for 5 cycles, out_ready others 1 -> out_valid=4'b0100, out_data stable, in_ready=0 for 5 cycles, fire on cycle 6, next target 3.
REQ-033 Load word to target 1, change mask to 4'b0001 while held -> word still goes to channel 1; next word targets 0.
REQ-034 Mask 0 -> in_ready=0, no accept; rst_n low mid-hold -> out_valid=0, busy=0 immediately, next target after reset is 0.
REQ-035 With CNT_EN, 260 fires on channel 0 only -> ch_cnt[7:0]=4, other bytes 0.

Source files
------------

// File: rtl/demux1_4_rr_dispatcher.sv
// One-word holding register that dispatches to one of four channels in round-robin order over ch_mask.
// Optional per-channel fire counters (ch_cnt) are built when DEMUX1_4_RR_DISPATCHER_CNT_EN is defined.
module demux1_4_rr_dispatcher #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        ch_mask,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
  output logic              busy
`ifdef DEMUX1_4_RR_DISPATCHER_CNT_EN
  ,
  output logic [31:0]       ch_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;

  logic       fire, accept, found;
  logic [1:0] base, idx, target;

  assign fire     = (state_q == FULL) & out_ready[sel_q];
  assign in_ready = (ch_mask != 4'b0) & ((state_q == EMPTY) | fire);
  assign accept   = in_valid & in_ready;

  // A load that coincides with a fire must search from the post-fire pointer.
  always_comb begin
    base   = fire ? sel_q + 2'd1 : ptr_q;
    target = base;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && ch_mask[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (fire) ptr_d = sel_q + 2'd1;
    if (accept) begin
      state_d = FULL;
      data_d  = in_data;
      sel_d   = target;
    end else if (fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy      = (state_q == FULL);
  assign out_valid = busy ? (4'b0001 << sel_q) : 4'b0000;
  assign out_data  = data_q;
  assign sel       = sel_q;

`ifdef DEMUX1_4_RR_DISPATCHER_CNT_EN
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    logic [7:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt_q <= 8'd0;
      else if (fire && sel_q == 2'(k)) cnt_q <= cnt_q + 8'd1;
    end
    assign ch_cnt[8*k +: 8] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_demux1_4_rr_dispatcher.sv
// Scoreboard bench: each task pushes the expected (sel, data) for the words it sends; a negedge monitor pops on every fire.
module tb_demux1_4_rr_dispatcher;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [3:0] ch_mask = 4'hF;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'h0;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
`ifdef DEMUX1_4_RR_DISPATCHER_CNT_EN
  logic [31:0] ch_cnt;
`endif

  demux1_4_rr_dispatcher #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ch_mask(ch_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sel(sel), .busy(busy)
`ifdef DEMUX1_4_RR_DISPATCHER_CNT_EN
    , .ch_cnt(ch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] sel; logic [7:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  logic chk_1010 = 1'b0;
  int   bad_1010 = 0;

  always @(negedge clk) begin
    if (rst_n && (out_valid & out_ready) != 4'b0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_fire: got out_valid=%b sel=%0d data=%h, want no fire", out_valid, sel, out_data);
      end else begin
        mon_e = sb.pop_front();
        if (sel !== mon_e.sel || out_data !== mon_e.data || out_valid !== (4'b0001 << mon_e.sel)) begin
          miscompares++;
          $display("FAIL dispatch: got sel=%0d data=%h out_valid=%b, want sel=%0d data=%h",
                   sel, out_data, out_valid, mon_e.sel, mon_e.data);
        end
      end
    end
    if (chk_1010 && (out_valid == 4'b0001 || out_valid == 4'b0100)) bad_1010++;
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'h0;
    repeat (2) @(posedge clk);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Present one word until accepted; expected target queued up front.
  task automatic send(input logic [7:0] d, input logic [1:0] s, output int waits);
    exp_t e;
    e.sel = s; e.data = d;
    sb.push_back(e);
    in_valid = 1'b1; in_data = d; waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 20) begin
        miscompares++;
        $display("FAIL send_timeout: got no accept for %h, want accept within 20 cycles", d);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d words pending, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (out_valid !== 4'b0 || busy !== 1'b0 || sel !== 2'd0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got out_valid=%b busy=%b sel=%0d data=%h, want 0 0 0 00", out_valid, busy, sel, out_data);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready_mask: got %b, want 1", in_ready);
    end
    ch_mask = 4'h0; #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_nomask: got %b, want 0", in_ready);
    end
    ch_mask = 4'hF;
  endtask

  task automatic test_rr_all();
    int w;
    do_reset(); ch_mask = 4'hF; out_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 2'(i), w);
      vectors++;
      if (w !== 0) begin
        miscompares++;
        $display("FAIL rr_all_in_ready: word %0d got %0d stall cycles, want 0", i, w);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_all_throughput: got pending=%0d busy=%b, want 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_mask_1010();
    int w;
    logic [1:0] tg [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset(); ch_mask = 4'b1010; out_ready = 4'hF;
    bad_1010 = 0; chk_1010 = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), tg[i], w);
    drain();
    chk_1010 = 1'b0;
    vectors++;
    if (bad_1010 != 0) begin
      miscompares++;
      $display("FAIL mask_1010_masked_valid: got %0d cycles on ch0/ch2, want 0", bad_1010);
    end
  endtask

  task automatic test_stall();
    int w;
    exp_t e;
    do_reset(); ch_mask = 4'hF; out_ready = 4'hF;
    send(8'h30, 2'd0, w);
    send(8'h31, 2'd1, w);
    out_ready = 4'b1011;
    send(8'h32, 2'd2, w);
    e.sel = 2'd3; e.data = 8'h33;
    sb.push_back(e);
    in_valid = 1'b1; in_data = 8'h33;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 4'b0100 || out_data !== 8'h32 || sel !== 2'd2 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold c%0d: got out_valid=%b data=%h sel=%0d in_ready=%b, want 0100 32 2 0",
                 c, out_valid, out_data, sel, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
  endtask

  task automatic test_retarget();
    int w;
    do_reset(); ch_mask = 4'hF; out_ready = 4'hF;
    send(8'h40, 2'd0, w);
    send(8'h41, 2'd1, w);
    out_ready = 4'h0; ch_mask = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 4'b0010 || sel !== 2'd1 || out_data !== 8'h41) begin
      miscompares++;
      $display("FAIL retarget_hold: got out_valid=%b sel=%0d data=%h, want 0010 1 41", out_valid, sel, out_data);
    end
    out_ready = 4'hF;
    send(8'h42, 2'd0, w);
    drain();
  endtask

  task automatic test_mask_zero_reset();
    int w;
    do_reset(); ch_mask = 4'h0; in_valid = 1'b1; in_data = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mask_zero c%0d: got in_ready=%b busy=%b, want 0 0", c, in_ready, busy);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ch_mask = 4'hF; out_ready = 4'h0;
    send(8'h50, 2'd0, w);
    out_ready = 4'b0001;
    send(8'h51, 2'd1, w);
    out_ready = 4'h0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0 || busy !== 1'b0 || sel !== 2'd0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got out_valid=%b busy=%b sel=%0d data=%h, want 0 0 0 00", out_valid, busy, sel, out_data);
    end
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 4'hF;
    send(8'h52, 2'd0, w);
    drain();
  endtask

`ifdef DEMUX1_4_RR_DISPATCHER_CNT_EN
  task automatic test_counters();
    int w;
    do_reset(); ch_mask = 4'b0001; out_ready = 4'hF;
    for (int i = 0; i < 260; i++) send(8'(i), 2'd0, w);
    drain();
    vectors++;
    if (ch_cnt !== 32'h0000_0004) begin
      miscompares++;
      $display("FAIL ch_cnt: got %h, want 00000004", ch_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_all();
    test_mask_1010();
    test_stall();
    test_retarget();
    test_mask_zero_reset();
`ifdef DEMUX1_4_RR_DISPATCHER_CNT_EN
    test_counters();
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
